score_sequencer: RTL
====================

Name: score_sequencer

Overview:
Game-level controller for the per-pixel scoring datapath. Sequences a dance session: idle → countdown → play (NUM_MOVES moves of FRAMES_PER_MOVE frames each) → done. Drives the scorer's `counting` enable, gated to the current move's target box, and its `update` commit strobe. Also issues a score-clear pulse at session start. Sits between the video timing generator and the scorer.

Parameters:
- FRAMES_PER_MOVE, 30, frames per move window (≥2)
- NUM_MOVES, 16, moves per session (≥1)
- COUNTDOWN_FRAMES, 90, frames of countdown before the first move (≥1)
- MOVE_W, $clog2(NUM_MOVES) (min 1), width of move_idx

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin/restart a session
- frame_start  in  1  one-cycle pulse at the start of each video frame
- pixel_valid  in  1  hcount/vcount address an active pixel this cycle
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- box_x0, box_x1  in  11 each  target box columns, inclusive
- box_y0, box_y1  in  10 each  target box rows, inclusive
- counting  out  1  scorer enable
- update  out  1  scorer commit level
- score_clear  out  1  one-cycle pulse; drives the scorer's reset
- move_idx  out  MOVE_W  current move number
- game_state  out  2  0 = IDLE, 1 = COUNTDOWN, 2 = PLAY, 3 = DONE
- frames_left  out  8  frames remaining in the current countdown or move (saturates at 255)
- done  out  1  high in DONE

Behaviour:
- **Reset:** all outputs are 0; state = IDLE; internal frame_cnt = 0; latched box = 0.
- **IDLE:**
  - start → COUNTDOWN, frame_cnt = 0, score_clear = 1 for the next cycle.
  - frame_start in the same cycle as start is not counted.
- **COUNTDOWN:**
  - Each frame_start increments frame_cnt.
  - On frame_start with frame_cnt == COUNTDOWN_FRAMES-1: go to PLAY, frame_cnt = 0, move_idx = 0, latch box_* inputs.
- **PLAY counting:**
  - counting is registered, 1-cycle latency: counting(t+1) = PLAY(t) & pixel_valid(t) & x0 ≤ hcount ≤ x1 & y0 ≤ vcount ≤ y1, compared against the latched box.
  - If x0 > x1 or y0 > y1, counting is never asserted.
- **PLAY update:**
  - update = registered (PLAY & frame_cnt == FRAMES_PER_MOVE-1).
  - It is a level spanning the whole final frame of each move, so the scorer's commit is sampled while counting pulses occur.
- **PLAY frame handling:** on frame_start:
  - If frame_cnt < FRAMES_PER_MOVE-1: frame_cnt++.
  - Otherwise: frame_cnt = 0.
    - If move_idx == NUM_MOVES-1: go to DONE.
    - Else: move_idx++ and re-latch box_* (new box takes effect from the next cycle).
- **DONE:**
  - done = 1; counting = 0; update = 0; move_idx holds its last value.
  - start → COUNTDOWN, with score_clear pulse, move_idx = 0.
- **frames_left** = limit − frame_cnt, where limit is COUNTDOWN_FRAMES or FRAMES_PER_MOVE for the current state; 0 in IDLE/DONE.
- **Boundary rules:**
  - start is ignored in COUNTDOWN and PLAY.
  - frame_start with no pixel_valid has no effect on counting.
  - reset at any point (mid-play included) returns to the reset values on the next edge; no update is emitted.
- frame_cnt and frame_start have no wrap other than as specified; frame_cnt never exceeds its limit − 1.

Optional Feature:
- Macro: SCORE_SEQ_PAUSE_EN.
- **With the macro:** adds input `pause` (1 bit).
  - While pause = 1 in COUNTDOWN or PLAY: frame_start is ignored, frame_cnt and move_idx freeze, and counting and update are forced to 0 (registered, 1-cycle latency).
  - start is still ignored.
  - Releasing pause resumes at the frozen count.
- **Without the macro:** no pause port and no pause logic.

Test Plan (FRAMES_PER_MOVE = 3, NUM_MOVES = 2, COUNTDOWN_FRAMES = 2):
1. reset, then start pulse → score_clear = 1 for one cycle; game_state = 1; frames_left = 2.
2. Two frame_start pulses in COUNTDOWN → game_state = 2; move_idx = 0; frames_left = 3.
3. PLAY, box (10..12, 5..5), sweep hcount 8..14 at vcount = 5 with pixel_valid → counting high exactly for the 3 cycles following hcount = 10, 11, 12; low at vcount = 6.
4. PLAY, frame_start ×2 → update goes high one cycle later and stays high until the next frame_start; move_idx then = 1 and the new box is latched.
5. Frame_starts continue to the end of move 1 → game_state = 3; done = 1; counting = 0 despite in-box pixels. start → game_state = 1 with score_clear pulse.
6. reset asserted mid-PLAY with counting = 1 → all outputs 0 next cycle. With SCORE_SEQ_PAUSE_EN: pause during PLAY → frame_start pulses ignored, counting = 0; after release, move ends after the remaining frames only.

Source files
------------

// File: rtl/score_sequencer_if.sv
// Bundle between the video timing generator, the score sequencer and the scorer.
// The pause input exists only when SCORE_SEQ_PAUSE_EN is defined.
interface score_sequencer_if #(
  parameter int unsigned MOVE_W = 4
);
  logic              start;
  logic              frame_start;
  logic              pixel_valid;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [10:0]       box_x0;
  logic [10:0]       box_x1;
  logic [9:0]        box_y0;
  logic [9:0]        box_y1;
`ifdef SCORE_SEQ_PAUSE_EN
  logic              pause;
`endif
  logic              counting;
  logic              update;
  logic              score_clear;
  logic [MOVE_W-1:0] move_idx;
  logic [1:0]        game_state;
  logic [7:0]        frames_left;
  logic              done;

  modport master (
    output start, frame_start, pixel_valid, hcount, vcount,
    output box_x0, box_x1, box_y0, box_y1,
`ifdef SCORE_SEQ_PAUSE_EN
    output pause,
`endif
    input  counting, update, score_clear, move_idx, game_state, frames_left, done
  );

  modport slave (
    input  start, frame_start, pixel_valid, hcount, vcount,
    input  box_x0, box_x1, box_y0, box_y1,
`ifdef SCORE_SEQ_PAUSE_EN
    input  pause,
`endif
    output counting, update, score_clear, move_idx, game_state, frames_left, done
  );
endinterface

// File: rtl/score_sequencer.sv
// Session controller: idle -> countdown -> NUM_MOVES moves -> done, gating the scorer.
// Optional pause input enabled by defining SCORE_SEQ_PAUSE_EN.
module score_sequencer #(
  parameter int unsigned FRAMES_PER_MOVE  = 30,
  parameter int unsigned NUM_MOVES        = 16,
  parameter int unsigned COUNTDOWN_FRAMES = 90,
  parameter int unsigned MOVE_W           = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
  input logic              clk,
  input logic              reset,
  score_sequencer_if.slave bus
);

  localparam int unsigned CntMax = (COUNTDOWN_FRAMES > FRAMES_PER_MOVE) ?
                                   COUNTDOWN_FRAMES : FRAMES_PER_MOVE;
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]   CdLast   = CntW'(COUNTDOWN_FRAMES - 1);
  localparam logic [CntW-1:0]   MoveLast = CntW'(FRAMES_PER_MOVE - 1);
  localparam logic [MOVE_W-1:0] LastMove = MOVE_W'(NUM_MOVES - 1);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StPlay      = 2'd2,
    StDone      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic [10:0]       x0_q, x1_q;
  logic [9:0]        y0_q, y1_q;
  logic              counting_q, counting_d;
  logic              update_q, update_d;
  logic              clear_q, clear_d;
  logic              latch_box;
  logic              paused;
  logic              frame_tick;
  logic              in_box;
  logic [31:0]       remaining;
  logic [7:0]        frames_left;

`ifdef SCORE_SEQ_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign frame_tick = bus.frame_start & ~paused;

  // An inverted box (x0 > x1 or y0 > y1) can never satisfy both bounds.
  assign in_box = (bus.hcount >= x0_q) && (bus.hcount <= x1_q) &&
                  (bus.vcount >= y0_q) && (bus.vcount <= y1_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    move_d     = move_q;
    latch_box  = 1'b0;
    clear_d    = 1'b0;
    counting_d = (state_q == StPlay) && bus.pixel_valid && in_box && !paused;
    update_d   = (state_q == StPlay) && (cnt_q == MoveLast) && !paused;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StCountdown;
          cnt_d   = '0;
          move_d  = '0;
          clear_d = 1'b1;
        end
      end
      StCountdown: begin
        if (frame_tick) begin
          if (cnt_q == CdLast) begin
            state_d   = StPlay;
            cnt_d     = '0;
            move_d    = '0;
            latch_box = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPlay: begin
        if (frame_tick) begin
          if (cnt_q < MoveLast) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (move_q == LastMove) begin
              state_d = StDone;
            end else begin
              move_d    = move_q + 1'b1;
              latch_box = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      move_q     <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      counting_q <= 1'b0;
      update_q   <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      move_q     <= move_d;
      counting_q <= counting_d;
      update_q   <= update_d;
      clear_q    <= clear_d;
      if (latch_box) begin
        x0_q <= bus.box_x0;
        x1_q <= bus.box_x1;
        y0_q <= bus.box_y0;
        y1_q <= bus.box_y1;
      end
    end
  end

  always_comb begin
    remaining = '0;
    case (state_q)
      StCountdown: remaining = COUNTDOWN_FRAMES - 32'(cnt_q);
      StPlay:      remaining = FRAMES_PER_MOVE - 32'(cnt_q);
      default:     remaining = '0;
    endcase
    frames_left = (remaining > 32'd255) ? 8'd255 : remaining[7:0];
  end

  assign bus.counting    = counting_q;
  assign bus.update      = update_q;
  assign bus.score_clear = clear_q;
  assign bus.move_idx    = move_q;
  assign bus.game_state  = state_q;
  assign bus.frames_left = frames_left;
  assign bus.done        = (state_q == StDone);

endmodule
